// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction cache refill engine.
//   - icache_refill_state_t : FSM state encoding (ST_FLUSH only with ICACHE_REFILL_FLUSH_EN)
//   - ICF_VALID / ICF_ERR   : bit positions inside the cam flags field
//   - CAM_INDEX_W / CAM_TAG_W : cam index and tag widths
//   - line_word_addr()      : word address of a refill beat, wrapping inside the line
// Optional feature macro: ICACHE_REFILL_FLUSH_EN
package icache_refill_pkg;

    localparam int ICF_VALID   = 0;
    localparam int ICF_ERR     = 1;
    localparam int CAM_INDEX_W = 10;
    localparam int CAM_TAG_W   = 17;

    typedef logic [28:2] word_addr_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_WRITE
`ifdef ICACHE_REFILL_FLUSH_EN
        , ST_FLUSH
`endif
    } icache_refill_state_t;

    // Upper line bits come from base untouched; the offset bits are
    // (critical word + beat count) with the carry out of the line dropped,
    // so the beat order wraps around inside the aligned line.
    function automatic word_addr_t line_word_addr(input word_addr_t base,
                                                  input logic [4:0] cnt,
                                                  input word_addr_t mask);
        word_addr_t wrapped;
        wrapped = base + word_addr_t'(cnt);
        return (base & ~mask) | (wrapped & mask);
    endfunction

endpackage

// File: rtl/icache_refill_if.sv
// Bus bundle of the refill engine: memory read port plus icache cam write port.
//   master : refill engine side (drives mem_req/mem_addr and the cam write port)
//   slave  : memory bus / cam side
//   mem_req, mem_addr[28:2], mem_gnt, mem_rvalid, mem_rdata[31:0], mem_rerr
//   rf_cam_write_index[11:2], rf_cam_write_req_data, rf_cam_write_data[31:0],
//   rf_cam_write_req_tag_flags, rf_cam_write_tag[28:12], rf_cam_write_flags[1:0]
interface icache_refill_if;

    logic        mem_req;
    logic [28:2] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_rerr;

    logic [11:2] rf_cam_write_index;
    logic        rf_cam_write_req_data;
    logic [31:0] rf_cam_write_data;
    logic        rf_cam_write_req_tag_flags;
    logic [28:12] rf_cam_write_tag;
    logic [1:0]  rf_cam_write_flags;

    modport master (
        output mem_req, mem_addr,
        input  mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
        output rf_cam_write_index, rf_cam_write_req_data, rf_cam_write_data,
        output rf_cam_write_req_tag_flags, rf_cam_write_tag, rf_cam_write_flags
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_gnt, mem_rvalid, mem_rdata, mem_rerr,
        input  rf_cam_write_index, rf_cam_write_req_data, rf_cam_write_data,
        input  rf_cam_write_req_tag_flags, rf_cam_write_tag, rf_cam_write_flags
    );

endinterface

// File: rtl/icache_refill.sv
// Instruction cache refill engine. On a fetch1 miss it reads one aligned line
// from the memory bus, critical word first, one outstanding request at a time,
// and writes every returned word into the cam. A bus error aborts the line.
// With ICACHE_REFILL_FLUSH_EN defined it can also sweep all 1024 cam entries
// to invalid.
// Ports:
//   clk_core, reset_n (synchronous, active low)
//   fe1_flush_req          : invalidate-all request (only with ICACHE_REFILL_FLUSH_EN)
//   fe1_refill_req/addr    : miss request and missing word address, sampled in IDLE
//   rf_busy                : engine not idle
//   rf_done / rf_err       : completion pulse, with abort-on-bus-error flag
//   bus (master)           : memory read port and cam write port
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int LINE_WORDS = 4
) (
    input  logic        clk_core,
    input  logic        reset_n,
`ifdef ICACHE_REFILL_FLUSH_EN
    input  logic        fe1_flush_req,
`endif
    input  logic        fe1_refill_req,
    input  logic [28:2] fe1_refill_addr,
    output logic        rf_busy,
    output logic        rf_done,
    output logic        rf_err,
    icache_refill_if.master bus
);

    localparam word_addr_t LINE_MASK = word_addr_t'(LINE_WORDS - 1);
    localparam logic [4:0] LAST_CNT  = 5'(LINE_WORDS - 1);

    icache_refill_state_t    state_q, state_d;
    word_addr_t              base_q, base_d;
    logic [4:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    mem_req_q, mem_req_d;
    word_addr_t              mem_addr_q, mem_addr_d;
    logic                    cam_req_data_q, cam_req_data_d;
    logic                    cam_req_tf_q, cam_req_tf_d;
    logic [CAM_INDEX_W-1:0]  cam_index_q, cam_index_d;
    logic [31:0]             cam_data_q, cam_data_d;
    logic [CAM_TAG_W-1:0]    cam_tag_q, cam_tag_d;
    logic [1:0]              cam_flags_q, cam_flags_d;
    logic                    done_q, done_d;
    logic                    done_err_q, done_err_d;

    // Next-state and next-output logic. All bus-facing outputs are computed
    // one cycle ahead here and registered, so the cam strobes are high for
    // exactly the WRITE cycle and mem_req for exactly the REQ cycles.
    // base holds the whole missing word address; its low bits are the
    // critical word offset.
    always_comb begin
        state_d        = state_q;
        base_d         = base_q;
        cnt_d          = cnt_q;
        err_d          = err_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        cam_req_data_d = 1'b0;
        cam_req_tf_d   = 1'b0;
        cam_index_d    = cam_index_q;
        cam_data_d     = cam_data_q;
        cam_tag_d      = cam_tag_q;
        cam_flags_d    = cam_flags_q;
        done_d         = 1'b0;
        done_err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
`ifdef ICACHE_REFILL_FLUSH_EN
                if (fe1_flush_req) begin
                    state_d      = ST_FLUSH;
                    cam_req_tf_d = 1'b1;
                    cam_index_d  = '0;
                    cam_tag_d    = '0;
                    cam_flags_d  = 2'b00;
                end else
`endif
                if (fe1_refill_req) begin
                    state_d    = ST_REQ;
                    base_d     = fe1_refill_addr;
                    cnt_d      = '0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fe1_refill_addr;
                end
            end

            ST_REQ: begin
                if (bus.mem_gnt) begin
                    state_d   = ST_WAIT;
                    mem_req_d = 1'b0;
                end
            end

            ST_WAIT: begin
                if (bus.mem_rvalid) begin
                    state_d                = ST_WRITE;
                    err_d                  = bus.mem_rerr;
                    cam_req_data_d         = 1'b1;
                    cam_req_tf_d           = 1'b1;
                    cam_index_d            = mem_addr_q[11:2];
                    cam_data_d             = bus.mem_rdata;
                    cam_tag_d              = base_q[28:12];
                    cam_flags_d[ICF_VALID] = 1'b1;
                    cam_flags_d[ICF_ERR]   = bus.mem_rerr;
                end
            end

            ST_WRITE: begin
                if (err_q || cnt_q == LAST_CNT) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    done_err_d = err_q;
                end else begin
                    state_d    = ST_REQ;
                    cnt_d      = cnt_q + 5'd1;
                    mem_req_d  = 1'b1;
                    mem_addr_d = line_word_addr(base_q, cnt_q + 5'd1, LINE_MASK);
                end
            end

`ifdef ICACHE_REFILL_FLUSH_EN
            // The cam index register doubles as the sweep counter; tag and
            // flags were zeroed on entry and stay zero throughout.
            ST_FLUSH: begin
                if (cam_index_q == '1) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cam_req_tf_d = 1'b1;
                    cam_index_d  = cam_index_q + 1'b1;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared by the synchronous reset so a reset
    // in any state drops every strobe on the next edge.
    always_ff @(posedge clk_core) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            base_q         <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            cam_req_data_q <= 1'b0;
            cam_req_tf_q   <= 1'b0;
            cam_index_q    <= '0;
            cam_data_q     <= '0;
            cam_tag_q      <= '0;
            cam_flags_q    <= '0;
            done_q         <= 1'b0;
            done_err_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            base_q         <= base_d;
            cnt_q          <= cnt_d;
            err_q          <= err_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            cam_req_data_q <= cam_req_data_d;
            cam_req_tf_q   <= cam_req_tf_d;
            cam_index_q    <= cam_index_d;
            cam_data_q     <= cam_data_d;
            cam_tag_q      <= cam_tag_d;
            cam_flags_q    <= cam_flags_d;
            done_q         <= done_d;
            done_err_q     <= done_err_d;
        end
    end

    assign rf_busy  = (state_q != ST_IDLE);
    assign rf_done  = done_q;
    assign rf_err   = done_err_q;

    assign bus.mem_req                    = mem_req_q;
    assign bus.mem_addr                   = mem_addr_q;
    assign bus.rf_cam_write_req_data      = cam_req_data_q;
    assign bus.rf_cam_write_req_tag_flags = cam_req_tf_q;
    assign bus.rf_cam_write_index         = cam_index_q;
    assign bus.rf_cam_write_data          = cam_data_q;
    assign bus.rf_cam_write_tag           = cam_tag_q;
    assign bus.rf_cam_write_flags         = cam_flags_q;

endmodule

// File: tb/tb_icache_refill.sv
// Self-checking bench for icache_refill (LINE_WORDS = 4). Expected cam writes
// and completions are queued when stimulus is issued; a monitor pops and
// compares whenever the DUT strobes the cam or pulses rf_done. A responder
// process models the memory bus with a configurable grant delay.
// The flush scenario is compiled only with ICACHE_REFILL_FLUSH_EN.
module tb_icache_refill;

    typedef struct packed {
        logic        req_data;
        logic        req_tf;
        logic [9:0]  index;
        logic [31:0] data;
        logic [16:0] tag;
        logic [1:0]  flags;
    } cam_wr_t;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic        clk_core;
    logic        reset_n;
`ifdef ICACHE_REFILL_FLUSH_EN
    logic        fe1_flush_req;
`endif
    logic        fe1_refill_req;
    logic [28:2] fe1_refill_addr;
    logic        rf_busy;
    logic        rf_done;
    logic        rf_err;

    icache_refill_if bus ();

    icache_refill #(.LINE_WORDS(4)) dut (
        .clk_core        (clk_core),
        .reset_n         (reset_n),
`ifdef ICACHE_REFILL_FLUSH_EN
        .fe1_flush_req   (fe1_flush_req),
`endif
        .fe1_refill_req  (fe1_refill_req),
        .fe1_refill_addr (fe1_refill_addr),
        .rf_busy         (rf_busy),
        .rf_done         (rf_done),
        .rf_err          (rf_err),
        .bus             (bus)
    );

    cam_wr_t exp_q[$];
    logic    done_q[$];
    resp_t   resp_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int gnt_delay = 0;
    int grant_count = 0;
    int stray_req_count = 0;

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushWrite(input logic [9:0] index, input logic [31:0] data,
                             input logic [16:0] tag, input logic [1:0] flags);
        cam_wr_t w;
        w.req_data = 1'b1;
        w.req_tf   = 1'b1;
        w.index    = index;
        w.data     = data;
        w.tag      = tag;
        w.flags    = flags;
        exp_q.push_back(w);
    endtask

    task automatic pushResp(input logic [31:0] data, input logic err);
        resp_t r;
        r.data = data;
        r.err  = err;
        resp_q.push_back(r);
    endtask

    // Pulse a refill request for one cycle; the engine must be busy with
    // the request on the bus right after the accepting edge.
    task automatic applyStimulus(input logic [28:2] addr);
        @(negedge clk_core);
        fe1_refill_req  = 1'b1;
        fe1_refill_addr = addr;
        @(negedge clk_core);
        fe1_refill_req  = 1'b0;
        checkOutput("req_accept", 64'({rf_busy, bus.mem_req, bus.mem_addr}), 64'({2'b11, addr}));
    endtask

    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (!rf_done && cycles < budget) begin
            @(negedge clk_core);
            cycles++;
        end
        if (!rf_done) checkOutput("done_timeout", 64'(rf_done), 64'(1));
    endtask

    // Memory bus model: grant after gnt_delay stall cycles, then return the
    // next queued response one cycle later. Also injects stray responses.
    initial begin
        int stray_done;
        logic [28:2] held_addr;
        resp_t r;
        stray_done     = 0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        bus.mem_rerr   = 1'b0;
        forever begin
            @(negedge clk_core);
            if (stray_done != stray_req_count) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = 32'hEEEE_EEEE;
                bus.mem_rerr   = 1'b0;
                @(negedge clk_core);
                bus.mem_rvalid = 1'b0;
                stray_done++;
            end else if (reset_n && bus.mem_req) begin
                held_addr = bus.mem_addr;
                for (int i = 0; i < gnt_delay; i++) begin
                    checkOutput("stall_req_addr", 64'({bus.mem_req, bus.mem_addr}), 64'({1'b1, held_addr}));
                    @(negedge clk_core);
                end
                bus.mem_gnt = 1'b1;
                grant_count++;
                @(negedge clk_core);
                bus.mem_gnt = 1'b0;
                if (resp_q.size() > 0) begin
                    r = resp_q.pop_front();
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = r.data;
                    bus.mem_rerr   = r.err;
                    @(negedge clk_core);
                    bus.mem_rvalid = 1'b0;
                end
            end
        end
    end

    // Scoreboard monitor: every cam strobe and every rf_done pulse must match
    // the head of its expectation queue. Data is ignored on tag-only writes.
    initial begin
        cam_wr_t act;
        cam_wr_t exp;
        logic    exp_err;
        forever begin
            @(negedge clk_core);
            if (reset_n) begin
                if (bus.rf_cam_write_req_data || bus.rf_cam_write_req_tag_flags) begin
                    if (exp_q.size() == 0) begin
                        checkOutput("cam_unexpected",
                                    64'({bus.rf_cam_write_req_data, bus.rf_cam_write_req_tag_flags}), 64'(0));
                    end else begin
                        exp          = exp_q.pop_front();
                        act.req_data = bus.rf_cam_write_req_data;
                        act.req_tf   = bus.rf_cam_write_req_tag_flags;
                        act.index    = bus.rf_cam_write_index;
                        act.data     = bus.rf_cam_write_data;
                        act.tag      = bus.rf_cam_write_tag;
                        act.flags    = bus.rf_cam_write_flags;
                        if (!exp.req_data) begin
                            act.data = '0;
                            exp.data = '0;
                        end
                        checkOutput("cam_write", 64'(act), 64'(exp));
                    end
                end
                if (rf_done) begin
                    if (done_q.size() == 0) begin
                        checkOutput("done_unexpected", 64'(rf_done), 64'(0));
                    end else begin
                        exp_err = done_q.pop_front();
                        checkOutput("done_err_busy", 64'({rf_err, rf_busy}), 64'({exp_err, 1'b0}));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int cyc;
        int g0;
        reset_n         = 1'b0;
        fe1_refill_req  = 1'b0;
        fe1_refill_addr = '0;
`ifdef ICACHE_REFILL_FLUSH_EN
        fe1_flush_req   = 1'b0;
`endif
        repeat (3) @(negedge clk_core);
        checkOutput("reset_ctrl", 64'({rf_busy, rf_done, rf_err, bus.mem_req,
                    bus.rf_cam_write_req_data, bus.rf_cam_write_req_tag_flags}), 64'(0));
        checkOutput("reset_mem_addr", 64'(bus.mem_addr), 64'(0));
        checkOutput("reset_cam", 64'({bus.rf_cam_write_index, bus.rf_cam_write_data,
                    bus.rf_cam_write_tag, bus.rf_cam_write_flags}), 64'(0));
        reset_n = 1'b1;
        @(negedge clk_core);

        $display("[TB] aligned refill");
        for (int i = 0; i < 4; i++) pushResp(32'hA0 + 32'(i), 1'b0);
        pushWrite(10'h000, 32'hA0, 17'h1, 2'b01);
        pushWrite(10'h001, 32'hA1, 17'h1, 2'b01);
        pushWrite(10'h002, 32'hA2, 17'h1, 2'b01);
        pushWrite(10'h003, 32'hA3, 17'h1, 2'b01);
        done_q.push_back(1'b0);
        g0 = grant_count;
        applyStimulus(27'h400);
        waitDone(40, cyc);
        checkOutput("aligned_latency", 64'(cyc), 64'(12));
        @(negedge clk_core);
        checkOutput("aligned_grants", 64'(grant_count - g0), 64'(4));
        checkOutput("aligned_idle", 64'({rf_busy, rf_done}), 64'(0));

        $display("[TB] critical word wrap");
        for (int i = 0; i < 4; i++) pushResp(32'hB0 + 32'(i), 1'b0);
        pushWrite(10'h236, 32'hB0, 17'h4, 2'b01);
        pushWrite(10'h237, 32'hB1, 17'h4, 2'b01);
        pushWrite(10'h234, 32'hB2, 17'h4, 2'b01);
        pushWrite(10'h235, 32'hB3, 17'h4, 2'b01);
        done_q.push_back(1'b0);
        applyStimulus(27'h1236);
        waitDone(40, cyc);
        checkOutput("wrap_latency", 64'(cyc), 64'(12));
        @(negedge clk_core);

        $display("[TB] bus error on second word");
        pushResp(32'hC0, 1'b0);
        pushResp(32'hC1, 1'b1);
        pushWrite(10'h008, 32'hC0, 17'h2, 2'b01);
        pushWrite(10'h009, 32'hC1, 17'h2, 2'b11);
        done_q.push_back(1'b1);
        g0 = grant_count;
        applyStimulus(27'h808);
        waitDone(40, cyc);
        checkOutput("err_latency", 64'(cyc), 64'(6));
        repeat (6) @(negedge clk_core);
        checkOutput("err_no_more_req", 64'({bus.mem_req, rf_busy}), 64'(0));
        checkOutput("err_grants", 64'(grant_count - g0), 64'(2));

        $display("[TB] grant stalled five cycles");
        gnt_delay = 5;
        for (int i = 0; i < 4; i++) pushResp(32'hD0 + 32'(i), 1'b0);
        pushWrite(10'h001, 32'hD0, 17'h1FFFF, 2'b01);
        pushWrite(10'h002, 32'hD1, 17'h1FFFF, 2'b01);
        pushWrite(10'h003, 32'hD2, 17'h1FFFF, 2'b01);
        pushWrite(10'h000, 32'hD3, 17'h1FFFF, 2'b01);
        done_q.push_back(1'b0);
        applyStimulus(27'h7FFFC01);
        waitDone(80, cyc);
        checkOutput("stall_latency", 64'(cyc), 64'(32));
        gnt_delay = 0;
        @(negedge clk_core);

        $display("[TB] reset while waiting for the response");
        applyStimulus(27'h400);
        @(negedge clk_core);
        checkOutput("in_wait", 64'({rf_busy, bus.mem_req}), 64'(2'b10));
        reset_n = 1'b0;
        @(negedge clk_core);
        reset_n = 1'b1;
        stray_req_count++;
        repeat (4) @(negedge clk_core);
        checkOutput("post_reset_ctrl", 64'({rf_busy, rf_done, bus.mem_req,
                    bus.rf_cam_write_req_data, bus.rf_cam_write_req_tag_flags}), 64'(0));
        checkOutput("post_reset_cam", 64'({bus.rf_cam_write_index, bus.rf_cam_write_data,
                    bus.rf_cam_write_tag, bus.rf_cam_write_flags}), 64'(0));

`ifdef ICACHE_REFILL_FLUSH_EN
        $display("[TB] flush wins over simultaneous refill");
        for (int i = 0; i < 1024; i++) begin
            cam_wr_t w;
            w.req_data = 1'b0;
            w.req_tf   = 1'b1;
            w.index    = 10'(i);
            w.data     = '0;
            w.tag      = '0;
            w.flags    = 2'b00;
            exp_q.push_back(w);
        end
        done_q.push_back(1'b0);
        g0 = grant_count;
        @(negedge clk_core);
        fe1_flush_req   = 1'b1;
        fe1_refill_req  = 1'b1;
        fe1_refill_addr = 27'h400;
        @(negedge clk_core);
        fe1_flush_req   = 1'b0;
        fe1_refill_req  = 1'b0;
        waitDone(1100, cyc);
        checkOutput("flush_latency", 64'(cyc), 64'(1024));
        repeat (4) @(negedge clk_core);
        checkOutput("flush_no_refill", 64'({grant_count - g0, 1'b0, bus.mem_req, rf_busy}), 64'(0));
`endif

        repeat (5) @(negedge clk_core);
        checkOutput("cam_queue_drained", 64'(exp_q.size()), 64'(0));
        checkOutput("done_queue_drained", 64'(done_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
